of_header_parser: RTL and testbench

OF_HEADER_PARSER -- requirements
Module: of_header_parser

---
 rtl/of_header_parser_pkg.sv | 38 +++
 rtl/of_header_parser.sv | 168 ++++++++++++++++
 tb/tb_of_header_parser.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/of_header_parser_pkg.sv
// Shared OpenFlow definitions: flow entry layout, queue header tag and VLAN TPID.
// Used by the header parser and the flow matcher.
package of_header_parser_pkg;

    localparam int unsigned FLOW_ENTRY_WIDTH = 142;

    // Bit positions of each field inside a flow entry (LSB index).
    localparam int unsigned SHORT_PKT_POS    = 0;
    localparam int unsigned VLAN_PRESENT_POS = 1;
    localparam int unsigned VLAN_ID_LO       = 2;
    localparam int unsigned DL_TYPE_LO       = 14;
    localparam int unsigned DL_SRC_LO        = 30;
    localparam int unsigned DL_DST_LO        = 78;
    localparam int unsigned IN_PORT_LO       = 126;

    localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hFF;
    localparam logic [15:0] VLAN_TPID          = 16'h8100;
    localparam logic [11:0] VLAN_ID_NONE       = 12'hFFF;

    typedef struct packed {
        logic [15:0] in_port;
        logic [47:0] dl_dst;
        logic [47:0] dl_src;
        logic [15:0] dl_type;
        logic [11:0] vlan_id;
        logic        vlan_present;
        logic        short_pkt;
    } flow_entry_t;

    typedef enum logic [2:0] {
        StWaitHdr,
        StWord0,
        StWord1,
        StWord2,
        StWaitEop
    } state_t;

endpackage

// File: rtl/of_header_parser.sv
// Forwards the packet bus with one cycle of delay while extracting the L2 header
// of each packet into a flow entry for the matcher.
module of_header_parser
    import of_header_parser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic [CTRL_WIDTH-1:0]       in_ctrl,
    input  logic                        in_wr,
    output logic                        in_rdy,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [CTRL_WIDTH-1:0]       out_ctrl,
    output logic                        out_wr,
    input  logic                        out_rdy,
    output logic [FLOW_ENTRY_WIDTH-1:0] flow_entry,
    output logic                        flow_wr,
    input  logic                        flow_nearly_full
);

    state_t      state_q, state_d;
    logic [15:0] in_port_q;
    logic [47:0] dl_dst_q;
    logic [47:0] dl_src_q;
    logic [15:0] tpid_q;
    logic [15:0] tci_q;
    flow_entry_t entry_d, entry_q;
    logic        flow_wr_q;
    logic        rdy_arm_q;
    logic        in_rdy_q;

    logic is_hdr, is_data, is_eop;
    logic cap_port, cap_w0, cap_w1, emit, emit_short;

    assign is_hdr  = in_wr && (in_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
    assign is_data = in_wr && (in_ctrl == '0);
    assign is_eop  = in_wr && (in_ctrl != '0) && !is_hdr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWaitHdr;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitHdr: if (is_hdr) state_d = StWord0;
            StWord0: begin
                if (is_eop) state_d = StWaitHdr;
                else if (is_data) state_d = StWord1;
            end
            StWord1: begin
                if (is_eop) state_d = StWaitHdr;
                else if (in_wr) state_d = StWord2;
            end
            StWord2:   if (in_wr) state_d = is_eop ? StWaitHdr : StWaitEop;
            StWaitEop: if (in_wr && (in_ctrl != '0)) state_d = StWaitHdr;
            default:   state_d = StWaitHdr;
        endcase
    end

    always_comb begin
        cap_port   = 1'b0;
        cap_w0     = 1'b0;
        cap_w1     = 1'b0;
        emit       = 1'b0;
        emit_short = 1'b0;
        unique case (state_q)
            StWaitHdr: cap_port = is_hdr;
            StWord0: begin
                cap_w0     = is_data;
                emit_short = is_eop;
            end
            StWord1: begin
                cap_w1     = in_wr;
                emit_short = is_eop;
            end
            StWord2:   emit = in_wr;
            StWaitEop: ;
            default:   ;
        endcase
    end

    always_comb begin
        entry_d         = '0;
        entry_d.in_port = in_port_q;
        entry_d.dl_dst  = dl_dst_q;
        // A short packet ending in WORD1 still carries the low source address bytes.
        entry_d.dl_src  = cap_w1 ? {dl_src_q[47:32], in_data[63:32]} : dl_src_q;
        if (tpid_q == VLAN_TPID) begin
            entry_d.vlan_present = 1'b1;
            entry_d.vlan_id      = tci_q[11:0];
            entry_d.dl_type      = in_data[63:48];
        end else begin
            entry_d.vlan_present = 1'b0;
            entry_d.vlan_id      = VLAN_ID_NONE;
            entry_d.dl_type      = tpid_q;
        end
        if (emit_short) begin
            entry_d.vlan_present = 1'b0;
            entry_d.vlan_id      = VLAN_ID_NONE;
            entry_d.dl_type      = '0;
            entry_d.short_pkt    = 1'b1;
        end
    end

    // Capture registers are cleared on each new header so a short packet reports zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_port_q <= '0;
            dl_dst_q  <= '0;
            dl_src_q  <= '0;
            tpid_q    <= '0;
            tci_q     <= '0;
        end else if (cap_port) begin
            in_port_q <= in_data[31:16];
            dl_dst_q  <= '0;
            dl_src_q  <= '0;
            tpid_q    <= '0;
            tci_q     <= '0;
        end else if (cap_w0) begin
            dl_dst_q         <= in_data[63:16];
            dl_src_q[47:32]  <= in_data[15:0];
        end else if (cap_w1) begin
            dl_src_q[31:0] <= in_data[63:32];
            tpid_q         <= in_data[31:16];
            tci_q          <= in_data[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q   <= '0;
            flow_wr_q <= 1'b0;
        end else begin
            flow_wr_q <= emit || emit_short;
            if (emit || emit_short) entry_q <= entry_d;
        end
    end

    // rdy_arm_q delays in_rdy by one extra edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_arm_q <= 1'b0;
            in_rdy_q  <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
            out_wr    <= 1'b0;
        end else begin
            rdy_arm_q <= 1'b1;
            in_rdy_q  <= rdy_arm_q && out_rdy && !flow_nearly_full;
            out_data  <= in_data;
            out_ctrl  <= in_ctrl;
            out_wr    <= in_wr;
        end
    end

    assign in_rdy     = in_rdy_q;
    assign flow_wr    = flow_wr_q;
    assign flow_entry = entry_q;

endmodule

// File: tb/tb_of_header_parser.sv
// Directed bench for of_header_parser: forwarding, flow entry extraction,
// short packets, back-to-back traffic, ready backpressure and mid-packet reset.
module tb_of_header_parser;

    localparam int FW = 142;

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   in_data;
    logic [7:0]    in_ctrl;
    logic          in_wr;
    logic          in_rdy;
    logic [63:0]   out_data;
    logic [7:0]    out_ctrl;
    logic          out_wr;
    logic          out_rdy;
    logic [FW-1:0] flow_entry;
    logic          flow_wr;
    logic          flow_nearly_full;

    int            tests = 0;
    int            fails = 0;
    int            flow_cnt = 0;
    int            cnt_before;
    logic [FW-1:0] last_entry = '0;
    logic [47:0]   dst, src;

    of_header_parser #(
        .DATA_WIDTH(64),
        .CTRL_WIDTH(8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_ctrl          (in_ctrl),
        .in_wr            (in_wr),
        .in_rdy           (in_rdy),
        .out_data         (out_data),
        .out_ctrl         (out_ctrl),
        .out_wr           (out_wr),
        .out_rdy          (out_rdy),
        .flow_entry       (flow_entry),
        .flow_wr          (flow_wr),
        .flow_nearly_full (flow_nearly_full)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [15:0] port, input logic [47:0] d,
                                         input logic [47:0] s, input logic [15:0] typ,
                                         input logic [11:0] vid, input logic vp,
                                         input logic sh);
        return {port, d, s, typ, vid, vp, sh};
    endfunction

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] c, input logic w);
        in_data = d;
        in_ctrl = c;
        in_wr   = w;
        @(posedge clk);
        #1;
        check("fwd", FW'({out_wr, out_ctrl, out_data}), FW'({w, c, d}));
        if (flow_wr) begin
            flow_cnt++;
            last_entry = flow_entry;
        end
        in_wr = 1'b0;
    endtask

    // Header, three parse words, extra payload words, then EOP word.
    task automatic send_pkt(input logic [15:0] port, input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] tpid, input logic [15:0] tci,
                            input logic [63:0] w2, input int extra);
        send({32'h0, port, 16'h0}, 8'hFF, 1'b1);
        send({d, s[47:32]}, 8'h00, 1'b1);
        send({s[31:0], tpid, tci}, 8'h00, 1'b1);
        check("no_flow_before_w2", FW'(flow_wr), FW'(0));
        send(w2, 8'h00, 1'b1);
        check("flow_wr_after_w2", FW'(flow_wr), FW'(1));
        for (int i = 0; i < extra; i++) send(64'h5A5A_0000_0000_0000 + 64'(i), 8'h00, 1'b1);
        send(64'hE0E0_E0E0_E0E0_E0E0, 8'h80, 1'b1);
    endtask

    initial begin
        reset            = 1'b1;
        in_data          = '0;
        in_ctrl          = '0;
        in_wr            = 1'b0;
        out_rdy          = 1'b1;
        flow_nearly_full = 1'b0;

        // Reset state
        #12;
        check("rst_in_rdy", FW'(in_rdy), FW'(0));
        check("rst_out", FW'({out_wr, out_ctrl, out_data}), FW'(0));
        check("rst_flow_wr", FW'(flow_wr), FW'(0));
        check("rst_flow_entry", flow_entry, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_rdy_first_edge", FW'(in_rdy), FW'(0));
        @(posedge clk);
        #1;
        check("in_rdy_second_edge", FW'(in_rdy), FW'(1));

        // Untagged packet
        cnt_before = flow_cnt;
        send_pkt(16'h0004, 48'h0A0B0C0D0E0F, 48'h111213141516, 16'h0800, 16'h0000,
                 64'hDEAD_BEEF_0000_0001, 1);
        check("untagged_count", FW'(flow_cnt - cnt_before), FW'(1));
        check("untagged_entry", last_entry,
              mk(16'h0004, 48'h0A0B0C0D0E0F, 48'h111213141516, 16'h0800, 12'hFFF, 1'b0, 1'b0));

        // Tagged packet
        cnt_before = flow_cnt;
        send_pkt(16'h0002, 48'h010203040506, 48'h0708090A0B0C, 16'h8100, 16'h6123,
                 64'h86DD_0000_0000_0000, 0);
        check("tagged_count", FW'(flow_cnt - cnt_before), FW'(1));
        check("tagged_entry", last_entry,
              mk(16'h0002, 48'h010203040506, 48'h0708090A0B0C, 16'h86DD, 12'h123, 1'b1, 1'b0));
        send(64'h0, 8'h00, 1'b0);
        check("entry_stable", flow_entry,
              mk(16'h0002, 48'h010203040506, 48'h0708090A0B0C, 16'h86DD, 12'h123, 1'b1, 1'b0));

        // Short packet: EOP arrives in WORD1
        cnt_before = flow_cnt;
        send(64'h0000_0000_0007_0000, 8'hFF, 1'b1);
        send(64'h2233_4455_6677_8899, 8'h00, 1'b1);
        check("short_no_flow_yet", FW'(flow_wr), FW'(0));
        send(64'hAABB_CCDD_0800_0000, 8'hC0, 1'b1);
        check("short_flow_wr", FW'(flow_wr), FW'(1));
        check("short_count", FW'(flow_cnt - cnt_before), FW'(1));
        check("short_entry", last_entry,
              mk(16'h0007, 48'h223344556677, 48'h8899AABBCCDD, 16'h0000, 12'hFFF, 1'b0, 1'b1));

        // Headerless traffic produces no entry
        cnt_before = flow_cnt;
        send(64'h1111, 8'h00, 1'b1);
        send(64'h2222, 8'h00, 1'b1);
        send(64'h3333, 8'h00, 1'b1);
        send(64'h4444, 8'h10, 1'b1);
        check("headerless_count", FW'(flow_cnt - cnt_before), FW'(0));

        // Three back-to-back 64-byte packets
        cnt_before = flow_cnt;
        for (int p = 0; p < 3; p++) begin
            dst = 48'hA0A0A0A0A000 + 48'(p);
            src = 48'hB0B0B0B0B000 + 48'(p);
            send_pkt(16'(p + 1), dst, src, 16'h0800, 16'h0000, 64'(p), 4);
            check("b2b_entry", last_entry, mk(16'(p + 1), dst, src, 16'h0800, 12'hFFF, 1'b0, 1'b0));
        end
        check("b2b_count", FW'(flow_cnt - cnt_before), FW'(3));

        // Nearly-full held for 10 cycles, a packet sent anyway
        flow_nearly_full = 1'b1;
        send(64'h0, 8'h00, 1'b0);
        check("nf_in_rdy_low", FW'(in_rdy), FW'(0));
        cnt_before = flow_cnt;
        send_pkt(16'h0009, 48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 16'h0806, 16'h0000,
                 64'h0, 0);
        for (int i = 0; i < 4; i++) send(64'h0, 8'h00, 1'b0);
        check("nf_in_rdy_still_low", FW'(in_rdy), FW'(0));
        check("nf_pkt_count", FW'(flow_cnt - cnt_before), FW'(1));
        check("nf_pkt_entry", last_entry,
              mk(16'h0009, 48'hC0C1C2C3C4C5, 48'hD0D1D2D3D4D5, 16'h0806, 12'hFFF, 1'b0, 1'b0));
        flow_nearly_full = 1'b0;
        send(64'h0, 8'h00, 1'b0);
        check("nf_release_in_rdy", FW'(in_rdy), FW'(1));

        // Reset asserted while in WORD1
        cnt_before = flow_cnt;
        send(64'h0000_0000_0003_0000, 8'hFF, 1'b1);
        send(64'h1234_5678_9ABC_DEF0, 8'h00, 1'b1);
        reset = 1'b1;
        #1;
        check("async_rst_out_wr", FW'(out_wr), FW'(0));
        check("async_rst_in_rdy", FW'(in_rdy), FW'(0));
        check("async_rst_entry", flow_entry, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(64'h0011_2233_0800_0000, 8'h00, 1'b1);
        send(64'h0, 8'h00, 1'b1);
        send(64'h0, 8'h00, 1'b1);
        send(64'h0, 8'h40, 1'b1);
        check("aborted_no_flow", FW'(flow_cnt - cnt_before), FW'(0));
        send_pkt(16'h0005, 48'h0F0E0D0C0B0A, 48'h060504030201, 16'h8100, 16'h0ABC,
                 64'h0800_0000_0000_0000, 1);
        check("post_rst_count", FW'(flow_cnt - cnt_before), FW'(1));
        check("post_rst_entry", last_entry,
              mk(16'h0005, 48'h0F0E0D0C0B0A, 48'h060504030201, 16'h0800, 12'hABC, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
